seven_seg_scan_ctrl: RTL

Time-multiplexing scan controller for a bank of common-anode/cathode 7-segment digits sharing one hex-to-segment decoder. It holds a double-buffered display word, steps through the digits with a programmable dwell and an inter-digit dead time, and presents one nibble plus a one-hot digit enable per cycle. It sits between the register/bus logic that writes display values and the shared decoder and digit drivers at the board pins.

---
 rtl/seven_seg_scan_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: double-buffered display word,
// per-digit guard/on slots, leading-zero and mask blanking, frame pulse.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    input  logic                          lz_suppress,
    output logic [3:0]                    nibble,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int ON_LEN = REFRESH_DIV - GUARD_CYCLES;

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_LEN - 1);
    localparam logic [CNT_W-1:0] ON_PEN     = CNT_W'(ON_LEN - 2);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_GUARD = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    // Bit i set when digit i and every more-significant digit hold zero; digit 0 never set.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [4*NUM_DIGITS-1:0] word);
        logic zero_above;
        zero_above = 1'b1;
        lz_mask    = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (word[4*i +: 4] == 4'd0);
            lz_mask[i] = zero_above;
        end
    endfunction

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic                    r_pend_v;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [3:0]              r_nibble;
    logic                    r_frame_done;

    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [4*NUM_DIGITS-1:0] w_pend_nxt;
    logic                    w_pend_v_nxt;
    logic [4*NUM_DIGITS-1:0] w_active_nxt;
    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic [3:0]              w_nibble_nxt;
    logic                    w_fd_nxt;
    logic                    w_xfer;
    logic                    w_bypass;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic                    w_digit_blank;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [3:0]              w_cur_nib;

    // Per-digit decode of the currently indexed slot.
    always_comb begin
        w_lz_mask     = lz_mask(r_active);
        w_digit_blank = blank_mask[r_idx] | (lz_suppress & w_lz_mask[r_idx]);
        w_onehot      = NUM_DIGITS'(1) << r_idx;
        w_cur_nib     = r_active[4*r_idx +: 4];
    end

    // Scan sequencing: next state, counters and the outputs of the state being entered.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_an_nxt     = r_an;
        w_nibble_nxt = r_nibble;
        w_fd_nxt     = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            ST_BLANK: begin
                w_an_nxt = '0;
                if (r_pend_v || load) begin
                    w_state_nxt = ST_GUARD;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_xfer      = 1'b1;
                end else begin
                    w_state_nxt = ST_BLANK;
                end
            end
            ST_GUARD: begin
                w_an_nxt = '0;
                if (r_cnt == GUARD_LAST) begin
                    w_state_nxt  = ST_ON;
                    w_cnt_nxt    = '0;
                    w_an_nxt     = w_digit_blank ? '0 : w_onehot;
                    w_nibble_nxt = w_cur_nib;
                    w_fd_nxt     = (ON_LAST == '0) && (r_idx == LAST_IDX);
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_ON: begin
                if (r_cnt == ON_LAST) begin
                    w_state_nxt = ST_GUARD;
                    w_cnt_nxt   = '0;
                    w_an_nxt    = '0;
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt = '0;
                        w_xfer    = r_pend_v;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_fd_nxt  = (r_cnt == ON_PEN) && (r_idx == LAST_IDX);
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_an_nxt    = '0;
            end
        endcase
    end

    // Buffer management; from BLANK with nothing pending the new value goes straight to active.
    always_comb begin
        w_bypass     = (r_state == ST_BLANK) && !r_pend_v;
        w_active_nxt = r_active;
        w_pend_v_nxt = r_pend_v;
        w_pend_nxt   = r_pend;
        if (w_xfer) begin
            w_active_nxt = w_bypass ? value : r_pend;
            w_pend_v_nxt = 1'b0;
        end else begin
            w_active_nxt = r_active;
        end
        if (load) begin
            w_pend_nxt = value;
            if (!(w_xfer && w_bypass)) begin
                w_pend_v_nxt = 1'b1;
            end else begin
                w_pend_v_nxt = 1'b0;
            end
        end else begin
            w_pend_nxt = r_pend;
        end
    end

    // State, buffer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_BLANK;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pend       <= '0;
            r_pend_v     <= 1'b0;
            r_active     <= '0;
            r_an         <= '0;
            r_nibble     <= 4'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_v     <= w_pend_v_nxt;
            r_active     <= w_active_nxt;
            r_an         <= w_an_nxt;
            r_nibble     <= w_nibble_nxt;
            r_frame_done <= w_fd_nxt;
        end
    end

    assign nibble     = r_nibble;
    assign an         = r_an;
    assign digit_idx  = r_idx;
    assign frame_done = r_frame_done;

endmodule
